nios_qsys_cpu_mul_seq: RTL and testbench
========================================

# nios_qsys_cpu_mul_seq

Multi-cycle 32x32 multiply sequencer for the Nios CPU datapath. It sits beside the M-stage 32-bit multiply cell and handles the operations that cell cannot: full 64-bit products (mulxuu, mulxsu, mulxss) and low-word mul. It feeds its own registered 16x16 unsigned partial-product multiplier, accumulates the four partial products, applies signed correction and returns one 32-bit word over a valid/ready handshake.

## Interface
- No parameters. Operand width is fixed at 32 and partial-product width at 16x16.
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start_valid  in  1  operation request
- start_ready  out  1  high only in IDLE; an operation is accepted on the edge where start_valid && start_ready
- op  in  2  operation select: 00 mul (low word), 01 mulxuu, 10 mulxsu (src1 signed, src2 unsigned), 11 mulxss
- src1  in  32  operand A; captured on accept
- src2  in  32  operand B; captured on accept
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts the result
- result  out  32  op 00: product[31:0]; all other ops: product[63:32]
- busy  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, ISSUE, DRAIN, CORR, DONE.
- IDLE: start_ready=1. On accept, register op, src1 (a) and src2 (b), clear acc[63:0] and cnt[1:0], then go to ISSUE.
- ISSUE spans 4 cycles with cnt=0..3. Each cycle drives the multiplier inputs:
  - cnt 0: a[15:0]*b[15:0], shift 0
  - cnt 1: a[31:16]*b[15:0], shift 16
  - cnt 2: a[15:0]*b[31:16], shift 16
  - cnt 3: a[31:16]*b[31:16], shift 32
- Multiplier: unsigned, registered, 1-cycle latency. pp_q[31:0] and its shift tag become valid the cycle after issue.
- Accumulate: acc <= acc + (pp_q << shift) in any cycle where pp_q is valid, i.e. ISSUE cnt 1..3 and DRAIN. Arithmetic is 64-bit, modulo 2^64.
- After cnt=3, go to DRAIN. DRAIN lasts 1 cycle, performs the last accumulate, then goes to CORR.
- CORR lasts 1 cycle. It updates acc[63:32] modulo 2^32:
  - subtract b if op[1]=1 and a[31]=1
  - subtract a if op=11 and b[31]=1
  - op 00 and op 01 pass through unchanged
- After CORR, go to DONE.
- DONE: result_valid=1 and result is a registered word, stable until handshake. On result_valid && result_ready, go to IDLE.
- start_valid outside IDLE is ignored; operations never overlap.
- Inputs src1, src2 and op changing after accept have no effect.

## Timing
- Reset values: start_ready=1, result_valid=0, result=0, busy=0. Internally: state=IDLE, acc=0, cnt=0, pp_q valid=0.
- Reset has priority over every other event, including reset in the same cycle as an accept or a result handshake. Reset mid-operation discards the operation, and the next cycle is IDLE.
- Accept at edge T:
  - ISSUE occupies cycles T+1..T+4.
  - DRAIN at T+5, CORR at T+6.
  - result_valid rises in cycle T+7. Fixed latency is 7 cycles, independent of op and operand values.
- A result handshake at the end of cycle T+7 returns to IDLE in T+8, where start_ready=1. The minimum issue interval is 8 cycles.
- Backpressure: with result_ready=0, the block holds DONE indefinitely. result and result_valid stay stable and start_ready stays 0.
- Boundary cases:
  - Operands 0x80000000 and 0xFFFFFFFF must give exact results for all ops.
  - Accumulator and correction wrap silently, with no overflow flag.

## Test plan
- Basic product, src1=0x00010002, src2=0x00030004:
  - op 00 -> result 0x000A0008
  - op 01 -> result 0x00000003
  - result_valid exactly 7 cycles after accept
- All-ones unsigned, src1=src2=0xFFFFFFFF:
  - op 00 -> 0x00000001
  - op 01 -> 0xFFFFFFFE
- Signed correction, src1=src2=0xFFFFFFFF:
  - op 10 -> 0xFFFFFFFF
  - op 11 -> 0x00000000
  - src1=0x80000000, src2=0x80000000, op 11 -> 0x40000000
- Backpressure: hold result_ready=0 for 5 cycles after result_valid while pulsing start_valid.
  - result held constant, start_ready=0, no second accept
  - the result is consumed on the first cycle result_ready=1
- Reset mid-operation: assert reset in cycle T+3 of an op 01 operation.
  - next cycle: busy=0, result_valid=0, start_ready=1
  - a following op 01 with 0xFFFFFFFF*0xFFFFFFFF returns 0xFFFFFFFE
- Streaming: hold start_valid=1 and result_ready=1 with alternating operands.
  - accepts occur every 8 cycles
  - results match the reference-model product for each op in order

Source files
------------

// File: rtl/nios_qsys_cpu_mul_seq_if.sv
// rtl/nios_qsys_cpu_mul_seq_if.sv - request/result handshake bundle for the multiply sequencer
//
// Signals:
//   start_valid  requester -> sequencer  operation request
//   start_ready  sequencer -> requester  high only while idle
//   op[1:0]      requester -> sequencer  00 mul, 01 mulxuu, 10 mulxsu, 11 mulxss
//   src1[31:0]   requester -> sequencer  operand A, captured on accept
//   src2[31:0]   requester -> sequencer  operand B, captured on accept
//   result_valid sequencer -> requester  result word available
//   result_ready requester -> sequencer  requester takes the result
//   result[31:0] sequencer -> requester  low or high product word
//   busy         sequencer -> requester  operation in flight

interface nios_qsys_cpu_mul_seq_if;
    logic        start_valid;
    logic        start_ready;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic        busy;

    modport master (
        output start_valid,
        output op,
        output src1,
        output src2,
        output result_ready,
        input  start_ready,
        input  result_valid,
        input  result,
        input  busy
    );

    modport slave (
        input  start_valid,
        input  op,
        input  src1,
        input  src2,
        input  result_ready,
        output start_ready,
        output result_valid,
        output result,
        output busy
    );
endinterface

// File: rtl/nios_qsys_cpu_mul_seq.sv
// rtl/nios_qsys_cpu_mul_seq.sv - multi-cycle 32x32 multiply sequencer built on a 16x16 partial-product cell
//
// Computes mul (low word), mulxuu, mulxsu and mulxss (high word) by issuing four
// 16x16 unsigned partial products into a registered multiplier, accumulating
// them into a 64-bit sum, then applying two's-complement correction to the
// high word. Fixed latency: result_valid rises 7 cycles after accept.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    slave side of nios_qsys_cpu_mul_seq_if (start/result handshakes, busy)

module nios_qsys_cpu_mul_seq (
    input  logic                     clk,
    input  logic                     reset,
    nios_qsys_cpu_mul_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_CORR,
        S_DONE
    } state_t;

    state_t      state;

    // Captured operation
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    // Accumulator and partial-product issue index
    logic [63:0] acc;
    logic [1:0]  cnt;

    // Registered 16x16 multiplier stage with its alignment tag
    logic [31:0] pp_q;
    logic [5:0]  pp_shift;
    logic        pp_valid;

    // Registered outputs
    logic        start_ready_q;
    logic        result_valid_q;
    logic        busy_q;
    logic [31:0] result_q;

    // Issue-side selects and correction terms
    logic [15:0] mul_x;
    logic [15:0] mul_y;
    logic [31:0] pp_next;
    logic [5:0]  issue_shift;
    logic [63:0] pp_aligned;
    logic [31:0] corr_b;
    logic [31:0] corr_a;
    logic [31:0] hi_corrected;

    always_comb begin
        // cnt[0] picks the half of A, cnt[1] the half of B:
        // 0 -> lo*lo, 1 -> hi*lo, 2 -> lo*hi, 3 -> hi*hi
        mul_x   = cnt[0] ? a_q[31:16] : a_q[15:0];
        mul_y   = cnt[1] ? b_q[31:16] : b_q[15:0];
        pp_next = {16'd0, mul_x} * {16'd0, mul_y};

        case (cnt)
            2'd0:    issue_shift = 6'd0;
            2'd3:    issue_shift = 6'd32;
            default: issue_shift = 6'd16;
        endcase

        pp_aligned = {32'd0, pp_q} << pp_shift;

        // Treating a negative operand as unsigned adds 2^32 * (other operand)
        // to the product, so the high word is corrected by subtracting it.
        corr_b       = (op_q[1] && a_q[31]) ? b_q : 32'd0;
        corr_a       = ((op_q == 2'b11) && b_q[31]) ? a_q : 32'd0;
        hi_corrected = acc[63:32] - corr_b - corr_a;
    end

    // Partial-product multiplier: one-cycle latency, product valid the cycle
    // after the matching ISSUE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pp_valid <= 1'b0;
            pp_q     <= 32'd0;
            pp_shift <= 6'd0;
        end else begin
            pp_valid <= (state == S_ISSUE);
            if (state == S_ISSUE) begin
                pp_q     <= pp_next;
                pp_shift <= issue_shift;
            end
        end
    end

    // Sequencer FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            op_q           <= 2'd0;
            a_q            <= 32'd0;
            b_q            <= 32'd0;
            acc            <= 64'd0;
            cnt            <= 2'd0;
            start_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= 32'd0;
        end else begin
            // Products land in ISSUE cnt 1..3 and DRAIN; never in IDLE or CORR,
            // so this cannot collide with the clear on accept or the correction.
            if (pp_valid) begin
                acc <= acc + pp_aligned;
            end

            case (state)
                S_IDLE: begin
                    if (bus.start_valid) begin
                        op_q          <= bus.op;
                        a_q           <= bus.src1;
                        b_q           <= bus.src2;
                        acc           <= 64'd0;
                        cnt           <= 2'd0;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    state <= S_CORR;
                end

                S_CORR: begin
                    acc[63:32]     <= hi_corrected;
                    result_q       <= (op_q == 2'b00) ? acc[31:0] : hi_corrected;
                    result_valid_q <= 1'b1;
                    state          <= S_DONE;
                end

                S_DONE: begin
                    if (bus.result_ready) begin
                        result_valid_q <= 1'b0;
                        start_ready_q  <= 1'b1;
                        busy_q         <= 1'b0;
                        state          <= S_IDLE;
                    end
                end

                default: begin
                    result_valid_q <= 1'b0;
                    start_ready_q  <= 1'b1;
                    busy_q         <= 1'b0;
                    state          <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready  = start_ready_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result       = result_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_nios_qsys_cpu_mul_seq.sv
// tb/tb_nios_qsys_cpu_mul_seq.sv - self-checking bench for the multiply sequencer

module tb_nios_qsys_cpu_mul_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;

    nios_qsys_cpu_mul_seq_if bus();

    nios_qsys_cpu_mul_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: sign- or zero-extend each operand to 64 bits and multiply.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ex;
        logic [63:0] ey;
        logic [63:0] p;
        ex = op[1]           ? {{32{x[31]}}, x} : {32'd0, x};
        ey = (op == 2'b11)   ? {{32{y[31]}}, y} : {32'd0, y};
        p  = ex * ey;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation: accept, scramble inputs, time result_valid, consume.
    task automatic do_op(input logic [1:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         output logic [31:0] res, output int lat);
        int n;
        n = 0;
        while (!bus.start_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.start_ready) check("start_ready_timeout", 0, 1);
        bus.op          = op;
        bus.src1        = s1;
        bus.src2        = s2;
        bus.start_valid = 1'b1;
        bus.result_ready = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        bus.op          = 2'($urandom);
        bus.src1        = $urandom;
        bus.src2        = $urandom;
        lat = 1;
        while (!bus.result_valid && lat < 30) begin
            tick();
            lat++;
        end
        if (!bus.result_valid) check("result_timeout", 0, 1);
        res = bus.result;
        tick();
        check("post_handshake_valid", bus.result_valid, 0);
        check("post_handshake_ready", bus.start_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        int          lat;
        logic [31:0] held;
        logic [1:0]  dir_op  [7];
        logic [31:0] dir_s1  [7];
        logic [31:0] dir_s2  [7];
        logic [31:0] dir_exp [7];
        logic [31:0] q[$];
        logic [31:0] exp_w;
        int          cyc;
        int          last_acc;
        int          n_acc;
        int          n_res;
        int          n;
        bit          accepted;

        bus.start_valid  = 1'b0;
        bus.op           = 2'd0;
        bus.src1         = 32'd0;
        bus.src2         = 32'd0;
        bus.result_ready = 1'b1;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        check("reset_start_ready", bus.start_ready, 1);
        check("reset_result_valid", bus.result_valid, 0);
        check("reset_result", bus.result, 0);
        check("reset_busy", bus.busy, 0);
        reset = 1'b0;
        tick();

        // Directed vectors with known answers
        dir_op[0] = 2'b00; dir_s1[0] = 32'h0001_0002; dir_s2[0] = 32'h0003_0004; dir_exp[0] = 32'h000A_0008;
        dir_op[1] = 2'b01; dir_s1[1] = 32'h0001_0002; dir_s2[1] = 32'h0003_0004; dir_exp[1] = 32'h0000_0003;
        dir_op[2] = 2'b00; dir_s1[2] = 32'hFFFF_FFFF; dir_s2[2] = 32'hFFFF_FFFF; dir_exp[2] = 32'h0000_0001;
        dir_op[3] = 2'b01; dir_s1[3] = 32'hFFFF_FFFF; dir_s2[3] = 32'hFFFF_FFFF; dir_exp[3] = 32'hFFFF_FFFE;
        dir_op[4] = 2'b10; dir_s1[4] = 32'hFFFF_FFFF; dir_s2[4] = 32'hFFFF_FFFF; dir_exp[4] = 32'hFFFF_FFFF;
        dir_op[5] = 2'b11; dir_s1[5] = 32'hFFFF_FFFF; dir_s2[5] = 32'hFFFF_FFFF; dir_exp[5] = 32'h0000_0000;
        dir_op[6] = 2'b11; dir_s1[6] = 32'h8000_0000; dir_s2[6] = 32'h8000_0000; dir_exp[6] = 32'h4000_0000;
        for (int i = 0; i < 7; i++) begin
            do_op(dir_op[i], dir_s1[i], dir_s2[i], res, lat);
            check($sformatf("directed_%0d", i), res, dir_exp[i]);
            check($sformatf("latency_%0d", i), lat, 7);
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [1:0]  rop;
            logic [31:0] r1;
            logic [31:0] r2;
            rop = 2'($urandom);
            r1  = pick();
            r2  = pick();
            do_op(rop, r1, r2, res, lat);
            check($sformatf("random_%0d_op%0d", i, rop), res, ref_mul(rop, r1, r2));
            check("random_latency", lat, 7);
        end

        // Backpressure: hold DONE while start_valid pulses
        bus.result_ready = 1'b0;
        bus.op           = 2'b10;
        bus.src1         = 32'h8000_0000;
        bus.src2         = 32'hFFFF_FFFF;
        bus.start_valid  = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        n = 1;
        while (!bus.result_valid && n < 30) begin
            tick();
            n++;
        end
        check("bp_latency", n, 7);
        held = bus.result;
        check("bp_result", held, ref_mul(2'b10, 32'h8000_0000, 32'hFFFF_FFFF));
        for (int i = 0; i < 5; i++) begin
            bus.start_valid = (i % 2 == 0);
            bus.src1        = $urandom;
            tick();
            check("bp_hold_result", bus.result, held);
            check("bp_hold_valid", bus.result_valid, 1);
            check("bp_start_ready", bus.start_ready, 0);
        end
        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b1;
        tick();
        check("bp_consumed_valid", bus.result_valid, 0);
        check("bp_consumed_busy", bus.busy, 0);
        check("bp_consumed_ready", bus.start_ready, 1);

        // Reset in cycle T+3 of an op 01 operation
        bus.op          = 2'b01;
        bus.src1        = 32'h1234_5678;
        bus.src2        = 32'h9ABC_DEF0;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        tick();
        check("midop_busy_before", bus.busy, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midop_busy", bus.busy, 0);
        check("midop_result_valid", bus.result_valid, 0);
        check("midop_start_ready", bus.start_ready, 1);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
        check("after_reset_result", res, 32'hFFFF_FFFE);
        check("after_reset_latency", lat, 7);

        // Streaming with start_valid and result_ready held high
        bus.result_ready = 1'b1;
        bus.op           = 2'b00;
        bus.src1         = $urandom;
        bus.src2         = 32'hFFFF_FFFF;
        bus.start_valid  = 1'b1;
        cyc      = 0;
        last_acc = -1;
        n_acc    = 0;
        n_res    = 0;
        while (n_res < 6 && cyc < 200) begin
            accepted = 1'b0;
            if (bus.start_ready && bus.start_valid) begin
                q.push_back(ref_mul(bus.op, bus.src1, bus.src2));
                if (last_acc >= 0) check("stream_interval", cyc - last_acc, 8);
                last_acc = cyc;
                n_acc++;
                accepted = 1'b1;
            end
            if (bus.result_valid) begin
                if (q.size() == 0) begin
                    check("stream_spurious_result", 1, 0);
                end else begin
                    exp_w = q.pop_front();
                    check($sformatf("stream_result_%0d", n_res), bus.result, exp_w);
                end
                n_res++;
            end
            tick();
            cyc++;
            if (accepted) begin
                bus.op = 2'(n_acc % 4);
                if (n_acc % 2 == 0) begin
                    bus.src1 = $urandom;
                    bus.src2 = 32'hFFFF_FFFF;
                end else begin
                    bus.src1 = 32'h8000_0000;
                    bus.src2 = $urandom;
                end
                if (n_acc >= 6) bus.start_valid = 1'b0;
            end
        end
        check("stream_results_seen", n_res, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
